// File: rtl/fft_iterative_stream_if.sv
// rtl/fft_iterative_stream_if.sv - sample-in / bin-out stream bundle for fft_iterative_stream
interface fft_iterative_stream_if #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 7,
  parameter int IDX_WIDTH = 3
);
  logic                        inverse;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  in_re;
  logic signed [IN_WIDTH-1:0]  in_im;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_re;
  logic signed [OUT_WIDTH-1:0] out_im;
  logic [IDX_WIDTH-1:0]        out_index;
  logic                        out_last;

  modport slave (
    input  inverse, in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_index, out_last
  );

  modport master (
    output inverse, in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_index, out_last
  );
endinterface

// File: rtl/fft_iterative_stream.sv
// rtl/fft_iterative_stream.sv - in-place radix-2 DIT FFT, one butterfly per clock
// Loads N samples bit-reversed, runs log2N stages in a register array, unloads bins in order.
module fft_iterative_stream #(
  parameter int N_POINTS = 8,
  parameter int IN_WIDTH = 4,
  parameter int TW_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fft_iterative_stream_if.slave   s,
  output logic                    busy
);
  localparam int LG        = $clog2(N_POINTS);
  localparam int OUT_WIDTH = IN_WIDTH + LG;
  localparam int HALF      = N_POINTS / 2;
  localparam int SH        = TW_WIDTH - 2;
  localparam int PW        = OUT_WIDTH + TW_WIDTH + 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [LG-1:0]   cnt_q, cnt_d;
  logic [LG-1:0]   stage_q, stage_d;
  logic [LG-2:0]   bfly_q, bfly_d;
  logic            full_q, full_d;
  logic            inv_q, inv_d;
  logic signed [OUT_WIDTH-1:0] re_q [N_POINTS];
  logic signed [OUT_WIDTH-1:0] im_q [N_POINTS];

  function automatic logic signed [TW_WIDTH-1:0] tw_round(real x);
    real y;
    y = x * (2.0 ** SH);
    if (y >= 0.0) return TW_WIDTH'($rtoi(y + 0.5));
    return TW_WIDTH'(-$rtoi(0.5 - y));
  endfunction

  function automatic logic [LG-1:0] bitrev(logic [LG-1:0] v);
    logic [LG-1:0] r;
    for (int b = 0; b < LG; b++) r[b] = v[LG-1-b];
    return r;
  endfunction

  logic signed [TW_WIDTH-1:0] cos_tab [HALF];
  logic signed [TW_WIDTH-1:0] sin_tab [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_tw
    localparam real ANG = 2.0 * 3.141592653589793 * g / N_POINTS;
    localparam logic signed [TW_WIDTH-1:0] C = tw_round($cos(ANG));
    localparam logic signed [TW_WIDTH-1:0] S = tw_round($sin(ANG));
    assign cos_tab[g] = C;
    assign sin_tab[g] = S;
  end

  logic                        in_ready_w, load_fire;
  logic [LG-1:0]               span, lo, top_idx, bot_idx;
  logic [LG-2:0]               tw_idx;
  logic signed [PW-1:0]        cx, sx, brx, bix, p_re, p_im;
  logic signed [OUT_WIDTH-1:0] a_re, a_im, t_re, t_im;

  assign in_ready_w  = (state_q == LOAD) && !full_q;
  assign load_fire   = s.in_valid && in_ready_w;
  assign s.in_ready  = in_ready_w;
  assign s.out_valid = (state_q == UNLOAD);
  assign s.out_re    = s.out_valid ? re_q[cnt_q] : '0;
  assign s.out_im    = s.out_valid ? im_q[cnt_q] : '0;
  assign s.out_index = s.out_valid ? cnt_q : '0;
  assign s.out_last  = s.out_valid && (cnt_q == LG'(N_POINTS - 1));
  assign busy        = (state_q != LOAD);

  // Butterfly addressing and the rounded twiddle product t = W * bot.
  always_comb begin
    span    = LG'(1) << stage_q;
    lo      = {1'b0, bfly_q} & (span - LG'(1));
    top_idx = (({1'b0, bfly_q} >> stage_q) << (stage_q + LG'(1))) | lo;
    bot_idx = top_idx + span;
    tw_idx  = (LG-1)'(lo << (LG'(LG - 1) - stage_q));
    cx      = PW'(cos_tab[tw_idx]);
    sx      = PW'(sin_tab[tw_idx]);
    if (inv_q) sx = -sx;
    brx     = PW'(re_q[bot_idx]);
    bix     = PW'(im_q[bot_idx]);
    a_re    = re_q[top_idx];
    a_im    = im_q[top_idx];
    p_re    = cx * brx + sx * bix;
    p_im    = cx * bix - sx * brx;
    t_re    = OUT_WIDTH'((p_re >>> SH) + $signed(PW'({1'b0, p_re[SH-1]})));
    t_im    = OUT_WIDTH'((p_im >>> SH) + $signed(PW'({1'b0, p_im[SH-1]})));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    full_d  = full_q;
    inv_d   = inv_q;
    case (state_q)
      LOAD: begin
        if (full_q) begin
          state_d = COMPUTE;
          full_d  = 1'b0;
        end else if (s.in_valid) begin
          if (cnt_q == '0) inv_d = s.inverse;
          if (cnt_q == LG'(N_POINTS - 1)) begin
            full_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + LG'(1);
          end
        end
      end
      COMPUTE: begin
        if (bfly_q == (LG-1)'(HALF - 1)) begin
          bfly_d = '0;
          if (stage_q == LG'(LG - 1)) begin
            stage_d = '0;
            state_d = UNLOAD;
          end else begin
            stage_d = stage_q + LG'(1);
          end
        end else begin
          bfly_d = bfly_q + (LG-1)'(1);
        end
      end
      UNLOAD: begin
        if (s.out_ready) begin
          if (cnt_q == LG'(N_POINTS - 1)) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + LG'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      full_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      full_q  <= full_d;
      inv_q   <= inv_d;
    end
  end

  // Sample storage carries no reset; contents are meaningless until a frame loads.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (load_fire) begin
        re_q[bitrev(cnt_q)] <= OUT_WIDTH'(s.in_re);
        im_q[bitrev(cnt_q)] <= OUT_WIDTH'(s.in_im);
      end else if (state_q == COMPUTE) begin
        re_q[top_idx] <= a_re + t_re;
        im_q[top_idx] <= a_im + t_im;
        re_q[bot_idx] <= a_re - t_re;
        im_q[bot_idx] <= a_im - t_im;
      end
    end
  end
endmodule

// File: tb/tb_fft_iterative_stream.sv
// tb/tb_fft_iterative_stream.sv - vector table plus scoreboard bench for fft_iterative_stream
module tb_fft_iterative_stream;
  localparam int N  = 8;
  localparam int IW = 4;
  localparam int OW = 7;
  localparam int LG = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  fft_iterative_stream_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .IDX_WIDTH(LG)) bus ();

  fft_iterative_stream #(.N_POINTS(N), .IN_WIDTH(IW), .TW_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave),
    .busy  (busy)
  );

  typedef struct packed {
    logic            inv;
    logic [7:0][7:0] xr;
    logic [7:0][7:0] xi;
    logic [7:0][7:0] er;
    logic [7:0][7:0] ei;
  } vec_t;

  typedef struct packed {
    logic [OW-1:0] re;
    logic [OW-1:0] im;
    logic [LG-1:0] idx;
    logic          last;
  } exp_t;

  vec_t  vecs [6];
  exp_t  sb_q [$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    first_valid_cyc = 0;
  bit    acc_flag = 0;
  bit    seen_valid = 0;
  bit    bp_mode = 0;
  bit    stalled = 0;
  logic [17:0] held;
  int    ring_re [8] = '{7, 5, 0, -5, -7, -5, 0, 5};
  int    ring_im [8] = '{0, 5, 7, 5, 0, -5, -7, -5};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [17:0] cur;
    exp_t e;
    if (bp_mode) bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      acc_flag = 1;
      acc_cyc  = cyc + 1;
    end
    cur = {bus.out_re, bus.out_im, bus.out_index, bus.out_last};
    if (bus.out_valid === 1'b1) begin
      if (!seen_valid) begin
        seen_valid      = 1;
        first_valid_cyc = cyc;
      end
      check("in_ready_low_in_unload", 32'(bus.in_ready), 32'd0);
      if (stalled) check("held_while_stalled", 32'(cur), 32'(held));
      if (bus.out_ready) begin
        stalled = 0;
        if (sb_q.size() == 0) begin
          check("unexpected_bin", 32'(cur), 32'h3ffff);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("bin%0d", e.idx), 32'(cur), 32'(e));
        end
      end else begin
        stalled = 1;
        held    = cur;
      end
    end else begin
      stalled = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_frame(int v, bit push);
    int n;
    exp_t e;
    seen_valid = 0;
    if (push) begin
      for (int i = 0; i < N; i++) begin
        e.re   = vecs[v].er[i][OW-1:0];
        e.im   = vecs[v].ei[i][OW-1:0];
        e.idx  = LG'(i);
        e.last = (i == N - 1);
        sb_q.push_back(e);
      end
    end
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 1)) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_re    = vecs[v].xr[i][IW-1:0];
      bus.in_im    = vecs[v].xi[i][IW-1:0];
      bus.inverse  = (i == 0) ? vecs[v].inv : ~vecs[v].inv;
      acc_flag = 0;
      n = 0;
      while (!acc_flag && n < 20) begin
        tick();
        n++;
      end
      check("sample_accepted", 32'(acc_flag), 32'd1);
    end
    // Sample offered while the block is full must be ignored.
    bus.in_re = 4'sd7;
    bus.in_im = -4'sd3;
    repeat (3) tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain_complete", 32'(sb_q.size()), 32'd0);
    check("post_frame_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_frame_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    for (int v = 0; v < 6; v++) begin
      vecs[v] = '0;
      for (int i = 0; i < N; i++) begin
        vecs[v].xr[i] = 8'((v == 2 || v == 3) ? ((i % 2 == 0) ? 1 : -1) : (v == 1 ? 1 : 0));
      end
    end
    vecs[0].xr[0] = 8'(-8);
    for (int i = 0; i < N; i++) vecs[0].er[i] = 8'(-8);
    vecs[1].er[0] = 8'd8;
    vecs[2].er[4] = 8'd8;
    vecs[3].inv   = 1'b1;
    vecs[3].er[4] = 8'd8;
    vecs[4].inv   = 1'b1;
    vecs[4].xr[1] = 8'd7;
    vecs[5].xr[1] = 8'd7;
    for (int i = 0; i < N; i++) begin
      vecs[4].er[i] = 8'(ring_re[i]);
      vecs[4].ei[i] = 8'(ring_im[i]);
      vecs[5].er[i] = 8'(ring_re[i]);
      vecs[5].ei[i] = 8'(-ring_im[i]);
    end

    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.inverse   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_index", 32'(bus.out_index), 32'd0);
    check("rst_out_data", 32'({bus.out_re, bus.out_im}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send_frame(v, 1);
      drain();
      if (v == 1) check("first_valid_latency", 32'(first_valid_cyc - acc_cyc), 32'd13);
    end

    bp_mode = 1;
    send_frame(4, 1);
    drain();
    send_frame(2, 1);
    drain();
    bp_mode = 0;
    bus.out_ready = 1'b1;

    send_frame(0, 0);
    repeat (3) tick();
    check("busy_in_compute", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    send_frame(0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
